// File: rtl/spi_config_sequencer_if.sv
// ----------------------------------------------------------------------------
// spi_config_sequencer_if
// Bundles the control handshake, readback status and SPI pins of the
// FRIDA configuration sequencer.
//   master : the sequencer side (drives SPI pins and status, reads requests)
//   slave  : the host / target side (drives requests and MISO, reads status)
// Signals:
//   start, abort, cfg_data          host request and word to load
//   busy, done, aborted             transfer status
//   rdback_data, rdback_valid,
//   mismatch                        readback of the previous register contents
//   spi_cs_b, spi_sclk, spi_sdi     SPI outputs (mode 0, CS active low)
//   spi_sdo                         SPI input from the target shift register
// ----------------------------------------------------------------------------
interface spi_config_sequencer_if #(
    parameter int NBITS = 180
);
    logic             start;
    logic             abort;
    logic [NBITS-1:0] cfg_data;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [NBITS-1:0] rdback_data;
    logic             rdback_valid;
    logic             mismatch;
    logic             spi_cs_b;
    logic             spi_sclk;
    logic             spi_sdi;
    logic             spi_sdo;

    modport master (
        input  start, abort, cfg_data, spi_sdo,
        output busy, done, aborted, rdback_data, rdback_valid, mismatch,
               spi_cs_b, spi_sclk, spi_sdi
    );

    modport slave (
        output start, abort, cfg_data, spi_sdo,
        input  busy, done, aborted, rdback_data, rdback_valid, mismatch,
               spi_cs_b, spi_sclk, spi_sdi
    );
endinterface

// File: rtl/spi_config_sequencer.sv
// ----------------------------------------------------------------------------
// spi_config_sequencer
// SPI master that loads an NBITS-long control word into the target shift
// register (MSB first, mode 0) and captures the old register contents that
// shift back on spi_sdo. The readback is compared with the last word written
// to flag configuration corruption.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active high
//   bus  : spi_config_sequencer_if.master (handshake, status, SPI pins)
// All outputs are registered.
// ----------------------------------------------------------------------------
module spi_config_sequencer #(
    parameter int NBITS    = 180,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    spi_config_sequencer_if.master    bus
);
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] tx_sr_q, tx_sr_d;
    logic [NBITS-1:0] rx_sr_q, rx_sr_d;
    logic [NBITS-1:0] cfg_q, cfg_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [NBITS-1:0] rdback_q, rdback_d;
    logic             rdback_valid_q, rdback_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             cs_b_q, cs_b_d;
    logic             sclk_q, sclk_d;
    logic             sdi_q, sdi_d;

    // Next-state and output computation for the transfer FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_cnt_d      = bit_cnt_q;
        tx_sr_d        = tx_sr_q;
        rx_sr_d        = rx_sr_q;
        cfg_d          = cfg_q;
        shadow_d       = shadow_q;
        rdback_d       = rdback_q;
        rdback_valid_d = rdback_valid_q;
        mismatch_d     = mismatch_q;
        done_d         = 1'b0;
        aborted_d      = 1'b0;
        cs_b_d         = cs_b_q;
        sclk_d         = sclk_q;
        sdi_d          = sdi_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort: abort is only looked at once busy
                if (bus.start) begin
                    state_d   = ST_SETUP;
                    tx_sr_d   = bus.cfg_data;
                    cfg_d     = bus.cfg_data;
                    cnt_d     = {CW{1'b0}};
                    bit_cnt_d = {BW{1'b0}};
                    cs_b_d    = 1'b0;
                    sclk_d    = 1'b0;
                    sdi_d     = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    cs_b_d    = 1'b1;
                    sclk_d    = 1'b0;
                    sdi_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = {CW{1'b0}};
                    sdi_d   = tx_sr_q[NBITS-1];
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_SHIFT: begin
                // sclk_q doubles as the phase flag: 0 = low phase, 1 = high phase
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    cs_b_d    = 1'b1;
                    sclk_d    = 1'b0;
                    sdi_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q != CW'(CLK_DIV - 1)) begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else if (!sclk_q) begin
                    // end of low phase: MISO has been stable since the previous falling edge
                    cnt_d   = {CW{1'b0}};
                    rx_sr_d = {rx_sr_q[NBITS-2:0], bus.spi_sdo};
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d     = {CW{1'b0}};
                    sclk_d    = 1'b0;
                    tx_sr_d   = {tx_sr_q[NBITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + {{(BW-1){1'b0}}, 1'b1};
                    if (bit_cnt_q == BW'(NBITS - 1)) begin
                        state_d = ST_HOLD;
                        sdi_d   = 1'b0;
                    end else begin
                        sdi_d   = tx_sr_q[NBITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    cs_b_d    = 1'b1;
                    sclk_d    = 1'b0;
                    sdi_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CW'(CS_HOLD - 1)) begin
                    // results become visible together with the done pulse
                    state_d        = ST_DONE;
                    cs_b_d         = 1'b1;
                    done_d         = 1'b1;
                    rdback_d       = rx_sr_q;
                    mismatch_d     = rdback_valid_q && (rx_sr_q != shadow_q);
                    shadow_d       = cfg_q;
                    rdback_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_b_d  = 1'b1;
                sclk_d  = 1'b0;
                sdi_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CW{1'b0}};
            bit_cnt_q      <= {BW{1'b0}};
            tx_sr_q        <= {NBITS{1'b0}};
            rx_sr_q        <= {NBITS{1'b0}};
            cfg_q          <= {NBITS{1'b0}};
            shadow_q       <= {NBITS{1'b0}};
            rdback_q       <= {NBITS{1'b0}};
            rdback_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            cs_b_q         <= 1'b1;
            sclk_q         <= 1'b0;
            sdi_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_sr_q        <= tx_sr_d;
            rx_sr_q        <= rx_sr_d;
            cfg_q          <= cfg_d;
            shadow_q       <= shadow_d;
            rdback_q       <= rdback_d;
            rdback_valid_q <= rdback_valid_d;
            mismatch_q     <= mismatch_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            cs_b_q         <= cs_b_d;
            sclk_q         <= sclk_d;
            sdi_q          <= sdi_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.rdback_data  = rdback_q;
    assign bus.rdback_valid = rdback_valid_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.spi_cs_b     = cs_b_q;
    assign bus.spi_sclk     = sclk_q;
    assign bus.spi_sdi      = sdi_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_config_sequencer
// Directed bench for spi_config_sequencer with a bit-accurate model of the
// target SPI shift register (captures MOSI on SCLK rise, shifts on SCLK fall,
// MISO = register MSB). A vector table drives back-to-back transfers; short
// hand-written sequences cover abort, start-while-busy and abort-in-DONE.
// ----------------------------------------------------------------------------
module tb_spi_config_sequencer;
    localparam int NB       = 180;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int LAT      = 1 + CS_SETUP + 2 * CLK_DIV * NB + CS_HOLD;

    localparam logic [NB-1:0] PWR = {45{4'h9}};
    localparam logic [NB-1:0] P0  = {{22{8'h5A}}, 4'h5};
    localparam logic [NB-1:0] P1  = {6{30'h2468ACE1}};
    localparam logic [NB-1:0] P2  = {{90{1'b1}}, {90{1'b0}}};
    localparam logic [NB-1:0] P3  = {60{3'b101}};
    localparam logic [NB-1:0] B90 = {{89{1'b0}}, 1'b1, {90{1'b0}}};

    typedef struct {
        logic [NB-1:0] cfg;
        logic          flip;
        logic [NB-1:0] exp_rd;
        logic          exp_mm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spi_config_sequencer_if #(.NBITS(NB)) bus ();

    spi_config_sequencer #(
        .NBITS(NB), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- target shift-register model ----------------
    logic [NB-1:0] tgt_q;
    logic          tgt_cap_q;
    logic          sclk_prev_q;
    int            rise_cnt_q;
    logic [NB-1:0] sdi_log_q;
    logic          flip_en;

    assign bus.spi_sdo = tgt_q[NB-1] ^ (flip_en && (rise_cnt_q == 89));

    always @(posedge clk) begin
        sclk_prev_q <= bus.spi_sclk;
        if (rst) begin
            tgt_q      <= PWR;
            tgt_cap_q  <= 1'b0;
            rise_cnt_q <= 0;
            sdi_log_q  <= '0;
        end else if (bus.spi_cs_b) begin
            rise_cnt_q <= 0;
        end else begin
            if (bus.spi_sclk && !sclk_prev_q) begin
                tgt_cap_q  <= bus.spi_sdi;
                sdi_log_q  <= {sdi_log_q[NB-2:0], bus.spi_sdi};
                rise_cnt_q <= rise_cnt_q + 1;
            end
            if (!bus.spi_sclk && sclk_prev_q) begin
                tgt_q <= {tgt_q[NB-2:0], tgt_cap_q};
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one transfer of cfg and run it until done (bounded).
    // lat = cycle index of done with the start cycle as 0; mm_pre = mismatch the cycle before done.
    task automatic xfer(input logic [NB-1:0] cfg, output int lat, output logic mm_pre);
        bus.cfg_data = cfg;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        chk("busy_after_start", NB'(bus.busy), NB'(1'b1));
        lat    = 1;
        mm_pre = bus.mismatch;
        while (!bus.done && lat < 2 * LAT) begin
            mm_pre = bus.mismatch;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t          vecs [5];
    int            lat;
    logic          mm_pre;
    logic [NB-1:0] prev_rd;
    logic          prev_mm;
    int            cnt;
    int            ndone;
    int            npulse;
    logic          seen_abort;

    initial begin
        vecs[0] = '{cfg: P0, flip: 1'b0, exp_rd: PWR,       exp_mm: 1'b0};
        vecs[1] = '{cfg: P1, flip: 1'b0, exp_rd: P0,        exp_mm: 1'b0};
        vecs[2] = '{cfg: P2, flip: 1'b0, exp_rd: P1,        exp_mm: 1'b0};
        vecs[3] = '{cfg: P3, flip: 1'b1, exp_rd: P2 ^ B90,  exp_mm: 1'b1};
        vecs[4] = '{cfg: P1, flip: 1'b0, exp_rd: P3,        exp_mm: 1'b0};

        // ---- reset with start held high ----
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.abort    = 1'b0;
        bus.cfg_data = P0;
        flip_en      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_b",         NB'(bus.spi_cs_b),     NB'(1'b1));
        chk("rst_sclk",         NB'(bus.spi_sclk),     NB'(1'b0));
        chk("rst_busy",         NB'(bus.busy),         NB'(1'b0));
        chk("rst_done",         NB'(bus.done),         NB'(1'b0));
        chk("rst_mismatch",     NB'(bus.mismatch),     NB'(1'b0));
        chk("rst_rdback_valid", NB'(bus.rdback_valid), NB'(1'b0));
        chk("rst_rdback_data",  bus.rdback_data,       '0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", NB'(bus.busy), NB'(1'b0));

        // ---- table-driven back-to-back transfers ----
        prev_rd = '0;
        prev_mm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flip_en = vecs[i].flip;
            chk($sformatf("v%0d_rd_held", i), bus.rdback_data, prev_rd);
            xfer(vecs[i].cfg, lat, mm_pre);
            chk($sformatf("v%0d_latency", i),  NB'(lat),              NB'(LAT));
            chk($sformatf("v%0d_mm_held", i),  NB'(mm_pre),           NB'(prev_mm));
            chk($sformatf("v%0d_done", i),     NB'(bus.done),         NB'(1'b1));
            chk($sformatf("v%0d_cs_b", i),     NB'(bus.spi_cs_b),     NB'(1'b1));
            chk($sformatf("v%0d_edges", i),    NB'(rise_cnt_q),       NB'(NB));
            chk($sformatf("v%0d_mosi", i),     sdi_log_q,             vecs[i].cfg);
            chk($sformatf("v%0d_rdback", i),   bus.rdback_data,       vecs[i].exp_rd);
            chk($sformatf("v%0d_mismatch", i), NB'(bus.mismatch),     NB'(vecs[i].exp_mm));
            chk($sformatf("v%0d_valid", i),    NB'(bus.rdback_valid), NB'(1'b1));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), NB'(bus.done), NB'(1'b0));
            chk($sformatf("v%0d_busy_end", i),   NB'(bus.busy), NB'(1'b0));
            prev_rd = vecs[i].exp_rd;
            prev_mm = vecs[i].exp_mm;
            flip_en = 1'b0;
        end

        // ---- abort at bit 50 of SHIFT ----
        bus.cfg_data = P2;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        cnt = 0;
        while (rise_cnt_q < 50 && cnt < 2 * LAT) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("abort_reached_bit50", NB'(rise_cnt_q), NB'(50));
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_pulse",   NB'(bus.aborted),  NB'(1'b1));
        chk("abort_cs_b",    NB'(bus.spi_cs_b), NB'(1'b1));
        chk("abort_sclk",    NB'(bus.spi_sclk), NB'(1'b0));
        chk("abort_sdi",     NB'(bus.spi_sdi),  NB'(1'b0));
        chk("abort_busy",    NB'(bus.busy),     NB'(1'b0));
        chk("abort_no_done", NB'(bus.done),     NB'(1'b0));
        @(posedge clk); #1;
        chk("abort_one_cycle", NB'(bus.aborted), NB'(1'b0));
        ndone = 0;
        for (int c = 0; c < LAT; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("abort_done_never", NB'(ndone),            NB'(0));
        chk("abort_rd_kept",    bus.rdback_data,       P3);
        chk("abort_valid_kept", NB'(bus.rdback_valid), NB'(1'b1));
        chk("abort_mm_kept",    NB'(bus.mismatch),     NB'(1'b0));
        xfer(P0, lat, mm_pre);
        chk("post_abort_latency", NB'(lat),        NB'(LAT));
        chk("post_abort_edges",   NB'(rise_cnt_q), NB'(NB));
        chk("post_abort_mosi",    sdi_log_q,       P0);
        @(posedge clk); #1;

        // ---- start+abort together in IDLE, then start pulses while busy ----
        bus.cfg_data = P3;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        chk("sa_busy",    NB'(bus.busy),     NB'(1'b1));
        chk("sa_cs_b",    NB'(bus.spi_cs_b), NB'(1'b0));
        chk("sa_aborted", NB'(bus.aborted),  NB'(1'b0));
        bus.cfg_data = P1;
        lat        = 1;
        npulse     = 0;
        seen_abort = 1'b0;
        while (!bus.done && lat < 2 * LAT) begin
            if ((lat % 100) == 10 && npulse < 10) begin
                bus.start = 1'b1;
                npulse++;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (bus.aborted) seen_abort = 1'b1;
        end
        bus.start = 1'b0;
        chk("ms_pulses",   NB'(npulse),          NB'(10));
        chk("ms_latency",  NB'(lat),             NB'(LAT));
        chk("ms_edges",    NB'(rise_cnt_q),      NB'(NB));
        chk("ms_mosi",     sdi_log_q,            P3);
        chk("ms_rdback",   bus.rdback_data,      P0);
        chk("ms_mismatch", NB'(bus.mismatch),    NB'(1'b0));
        chk("ms_no_abort", NB'(seen_abort),      NB'(1'b0));
        // abort raised during the DONE cycle is ignored
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("done_abort_ignored", NB'(bus.aborted), NB'(1'b0));
        chk("done_abort_idle",    NB'(bus.busy),    NB'(1'b0));
        chk("done_abort_rd",      bus.rdback_data,  P0);
        ndone = 0;
        for (int c = 0; c < LAT + 50; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("ms_single_transfer", NB'(ndone), NB'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
